axil_slave_regfile: RTL and testbench

//  Parametrised AXI-Lite slave register file for bench and SoC use: NUM_REGS words, byte-strobed writes.

---
 rtl/axil_slave_regfile.sv | 210 +++++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register file: byte-strobed writes, independent AW/W capture,
// programmable write/read response latency, DECERR/SLVERR decode.
module axil_slave_regfile #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16,
  parameter int RO_BASE        = NUM_REGS,
  parameter int RESET_OFFSET   = 'h1000,
  parameter int WR_LATENCY     = 0,
  parameter int RD_LATENCY     = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH:0] ADDR_LIMIT = (AXI_ADDR_WIDTH+1)'(NUM_REGS * BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_WAIT = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;
  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return addr[LSB +: IDX_W];
  endfunction

  function automatic logic addr_out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} >= ADDR_LIMIT;
  endfunction

  function automatic logic [1:0] wr_resp_of(input logic [AXI_ADDR_WIDTH-1:0] addr);
    if (addr_out_of_range(addr))
      return RESP_DECERR;
    else if (int'(addr_idx(addr)) >= RO_BASE)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [NUM_REGS];

  logic [1:0]                wr_state;
  logic                      aw_held, w_held;
  logic [3:0]                wr_cnt;
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]          w_strb_q;

  logic [1:0]                rd_state;
  logic [3:0]                rd_cnt;
  logic                      rvalid_q;
  logic [1:0]                rresp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]          rd_idx_q;
  logic                      rd_err_q;

  logic aw_hs, w_hs, ar_hs, wr_commit;
  logic [1:0] commit_resp;

  // Readies are forced low while reset is asserted, not just after the next edge.
  assign s_axil_awready = aresetn && (wr_state == WR_IDLE) && !aw_held;
  assign s_axil_wready  = aresetn && (wr_state == WR_IDLE) && !w_held;
  assign s_axil_arready = aresetn && (rd_state == RD_IDLE);
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign aw_hs       = s_axil_awvalid && s_axil_awready;
  assign w_hs        = s_axil_wvalid && s_axil_wready;
  assign ar_hs       = s_axil_arvalid && s_axil_arready;
  assign wr_commit   = (wr_state == WR_WAIT) && (wr_cnt == 4'd0);
  assign commit_resp = wr_resp_of(aw_addr_q);

  // Write channel: capture AW/W independently, count down latency, hold B
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_cnt   <= 4'd0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) aw_held <= 1'b1;
          if (w_hs)  w_held  <= 1'b1;
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            wr_state <= WR_WAIT;
            wr_cnt   <= 4'(WR_LATENCY);
          end
        end
        WR_WAIT: begin
          if (wr_cnt == 4'd0) begin
            bresp_q  <= commit_resp;
            bvalid_q <= 1'b1;
            wr_state <= WR_RESP;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) aw_addr_q <= s_axil_awaddr;
    if (w_hs) begin
      w_data_q <= s_axil_wdata;
      w_strb_q <= s_axil_wstrb;
    end
  end

  // Register storage: reset reload and strobed commit
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= AXI_DATA_WIDTH'(i * BYTES + RESET_OFFSET);
    end else if (wr_commit && (commit_resp == RESP_OKAY)) begin
      for (int b = 0; b < BYTES; b++)
        if (w_strb_q[b])
          mem[addr_idx(aw_addr_q)][b*8 +: 8] <= w_data_q[b*8 +: 8];
    end
  end

  // Read channel: latch decode on AR, count down latency, capture and hold R
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= 4'd0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_cnt   <= 4'(RD_LATENCY);
            rd_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_cnt == 4'd0) begin
            // Same-edge write commit is non-blocking, so this sees the old word.
            rdata_q  <= rd_err_q ? '0 : mem[rd_idx_q];
            rresp_q  <= rd_err_q ? RESP_DECERR : RESP_OKAY;
            rvalid_q <= 1'b1;
            rd_state <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            rvalid_q <= 1'b0;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      rd_idx_q <= addr_idx(s_axil_araddr);
      rd_err_q <= addr_out_of_range(s_axil_araddr);
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: 16 words, RO from word 12,
// write latency 2, read latency 1, 32-bit data.
module tb_axil_slave_regfile;

  localparam int WR_LAT = 2;
  localparam int RD_LAT = 1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [16];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  axil_slave_regfile #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_REGS(16), .RO_BASE(12),
    .RESET_OFFSET('h1000), .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h1000 + 32'(i * 4);
  endtask

  function automatic logic [1:0] tb_resp(input logic [31:0] a, input bit wr);
    if (a >= 32'h40) return 2'b11;
    if (wr && (a[5:2] >= 4'd12)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay,
                           input int bready_delay, input bit stall_aw, output int aw_to_b);
    logic [1:0] er, eb, b0;
    int cyc, aw_e, last_e;
    bit aw_done, w_done, aw_hs, w_hs;
    er = tb_resp(addr, 1'b1);
    exp_b.push_back(er);
    if (er == 2'b00)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = (aw_delay == 0); wvalid = (w_delay == 0);
    cyc = 0; aw_e = 0; last_e = 0; aw_done = 0; w_done = 0; aw_to_b = -1;
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk); #1; cyc++;
      if (aw_hs) begin aw_done = 1; awvalid = 0; aw_e = cyc; end
      if (w_hs)  begin w_done = 1;  wvalid = 0; end
      if (aw_hs || w_hs) last_e = cyc;
      if (!aw_done && cyc >= aw_delay) awvalid = 1;
      if (!w_done && cyc >= w_delay) wvalid = 1;
    end
    n_checks++;
    if (!(aw_done && w_done)) begin
      $display("FAIL wr_accept addr=%h aw_done=%0d w_done=%0d required both 1", addr, aw_done, w_done);
      n_fail++; awvalid = 0; wvalid = 0; void'(exp_b.pop_front()); return;
    end
    while (!bvalid && cyc < last_e + 40) begin @(posedge aclk); #1; cyc++; end
    eb = exp_b.pop_front();
    n_checks++;
    if (!bvalid) begin
      $display("FAIL wr_bvalid_timeout addr=%h bvalid=0 required 1", addr);
      n_fail++; return;
    end
    aw_to_b = cyc - aw_e;
    n_checks++;
    if (cyc - last_e !== WR_LAT + 1) begin
      $display("FAIL wr_latency addr=%h got %0d required %0d", addr, cyc - last_e, WR_LAT + 1);
      n_fail++;
    end
    n_checks++;
    if (bresp !== eb) begin
      $display("FAIL wr_bresp addr=%h got %b required %b", addr, bresp, eb);
      n_fail++;
    end
    b0 = bresp;
    if (stall_aw) begin awaddr = addr; awvalid = 1; end
    for (int i = 0; i < bready_delay; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, b0, 1'b0, 1'b0}) begin
        $display("FAIL wr_hold bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                 bvalid, bresp, awready, wready, b0);
        n_fail++;
      end
    end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    n_checks++;
    if (bvalid !== 1'b0) begin
      $display("FAIL wr_bvalid_clear got %b required 0", bvalid);
      n_fail++;
    end
    if (stall_aw) begin
      n_checks++;
      if (awready !== 1'b1) begin
        $display("FAIL wr_aw_resume awready=%b required 1", awready);
        n_fail++;
      end
      awvalid = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_delay);
    logic [1:0]  er;
    logic [33:0] ex;
    logic [31:0] d0;
    int cyc;
    er = tb_resp(addr, 1'b0);
    exp_r.push_back({er, (er == 2'b11) ? 32'h0 : model_mem[addr[5:2]]});
    araddr = addr; arvalid = 1; cyc = 0;
    while (!arready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    arvalid = 0; cyc = 0;
    while (!rvalid && cyc < 40) begin @(posedge aclk); #1; cyc++; end
    ex = exp_r.pop_front();
    n_checks++;
    if (!rvalid) begin
      $display("FAIL rd_rvalid_timeout addr=%h rvalid=0 required 1", addr);
      n_fail++; return;
    end
    n_checks++;
    if (cyc !== RD_LAT + 1) begin
      $display("FAIL rd_latency addr=%h got %0d required %0d", addr, cyc, RD_LAT + 1);
      n_fail++;
    end
    n_checks++;
    if ({rresp, rdata} !== ex) begin
      $display("FAIL rd_data addr=%h got resp=%b data=%h required resp=%b data=%h",
               addr, rresp, rdata, ex[33:32], ex[31:0]);
      n_fail++;
    end
    d0 = rdata;
    for (int i = 0; i < rready_delay; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if ({rvalid, rresp, rdata} !== {1'b1, ex[33:32], d0}) begin
        $display("FAIL rd_hold rvalid=%b rresp=%b rdata=%h required 1 %b %h",
                 rvalid, rresp, rdata, ex[33:32], d0);
        n_fail++;
      end
    end
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    n_checks++;
    if (rvalid !== 1'b0) begin
      $display("FAIL rd_rvalid_clear got %b required 0", rvalid);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      $display("FAIL reset_handshake got %b required 00000", {awready, wready, arready, bvalid, rvalid});
      n_fail++;
    end
    n_checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      $display("FAIL reset_resp_data bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata);
      n_fail++;
    end
    aresetn = 1;
    model_reset();
    @(posedge aclk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      $display("FAIL reset_release_ready got %b required 111", {awready, wready, arready});
      n_fail++;
    end
  endtask

  task automatic test_reset_read();
    axi_read(32'h0C, 0);
  endtask

  task automatic test_partial_write();
    int lat;
    axi_write(32'h04, 32'hAABBCCDD, 4'b0011, 0, 3, 0, 0, lat);
    n_checks++;
    if (lat !== 6) begin
      $display("FAIL aw_to_bvalid got %0d required 6", lat);
      n_fail++;
    end
    axi_read(32'h04, 0);
  endtask

  task automatic test_slverr();
    int lat;
    axi_write(32'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, lat);
    axi_read(32'h30, 0);
  endtask

  task automatic test_decerr();
    int lat;
    axi_read(32'h40, 0);
    axi_write(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, lat);
    for (int i = 0; i < 16; i++) axi_read(32'(i * 4), 0);
  endtask

  task automatic test_backpressure();
    int lat;
    axi_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 5, 1, lat);
    axi_read(32'h10, 3);
  endtask

  task automatic test_back_to_back();
    int lat;
    axi_write(32'h08, 32'h12345678, 4'b1100, 2, 0, 0, 0, lat);
    axi_write(32'h2C, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, lat);
    axi_write(32'h2E, 32'h99887766, 4'b0100, 0, 1, 1, 0, lat);
    axi_read(32'h08, 0);
    axi_read(32'h2D, 1);
    axi_read(32'h3C, 0);
  endtask

  task automatic test_reset_midread();
    int lat;
    axi_write(32'h04, 32'h55555555, 4'hF, 0, 0, 0, 0, lat);
    araddr = 32'h04; arvalid = 1;
    @(posedge aclk); #1;
    arvalid = 0;
    aresetn = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if ({rvalid, arready} !== 2'b00) begin
        $display("FAIL midread_reset cycle %0d rvalid=%b arready=%b required 0 0", i, rvalid, arready);
        n_fail++;
      end
    end
    aresetn = 1;
    model_reset();
    @(posedge aclk); #1;
    axi_read(32'h04, 0);
  endtask

  initial begin
    aresetn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arvalid = 0; rready = 0;
    model_reset();
    test_reset();
    test_reset_read();
    test_partial_write();
    test_slverr();
    test_decerr();
    test_backpressure();
    test_back_to_back();
    test_reset_midread();
    n_checks++;
    if (exp_b.size() + exp_r.size() !== 0) begin
      $display("FAIL scoreboard_drain left %0d required 0", exp_b.size() + exp_r.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
